// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between load/store (p0) and debug (p1).
// Define DMEM_ARB_RR_EN for round-robin on contention; default is fixed priority to p0.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p0_gnt,
  output logic              p1_gnt,
  output logic              p0_rvalid,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic             last_gnt_q, last_gnt_d;
  logic             owner_q, owner_d;
  logic             rd_pend_q, rd_pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             both;
  logic             pick1;

  // Pick a winner from the requests and the last grant only.
  always_comb begin
    both = p0_req & p1_req;
`ifdef DMEM_ARB_RR_EN
    pick1 = both ? ~last_gnt_q : p1_req;
`else
    pick1 = p1_req & ~p0_req;
`endif
    p0_gnt = ~rst & p0_req & ~pick1;
    p1_gnt = ~rst & p1_req & pick1;
  end

  // Steer the granted port onto the memory bus; idle bus is all zero.
  always_comb begin
    mem_en    = p0_gnt | p1_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      p0_gnt: begin
        mem_we    = p0_we;
        mem_addr  = p0_addr;
        mem_wdata = p0_wdata;
      end
      p1_gnt: begin
        mem_we    = p1_we;
        mem_addr  = p1_addr;
        mem_wdata = p1_wdata;
      end
      default: ;
    endcase
  end

  // Next state for read tracking, last grant and the contention counter.
  always_comb begin
    rd_pend_d  = mem_en & ~mem_we;
    owner_d    = mem_en ? p1_gnt : owner_q;
    last_gnt_d = mem_en ? p1_gnt : last_gnt_q;
    cnt_d      = cnt_q;
    if (both && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // State registers; reset leaves port 0 preferred next.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q  <= 1'b0;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      cnt_q      <= '0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
    end
  end

  // A read in flight when reset arrives is dropped, so rst masks rvalid.
  assign p0_rvalid    = rd_pend_q & ~owner_q & ~rst;
  assign p1_rvalid    = rd_pend_q & owner_q & ~rst;
  assign p0_rdata     = p0_rvalid ? mem_rdata : '0;
  assign p1_rdata     = p1_rvalid ? mem_rdata : '0;
  assign conflict_cnt = cnt_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port, synchronous-read data memory between the processor load/store path (port 0) and a debug/loader port (port 1). It sits between the processor and the data memory inside the SoC. It grants at most one access per cycle, issues it to the memory, and returns read data to the owning port one cycle later. It also keeps a saturating count of contention cycles for performance debug.

## Interface
- ADDR_W, 5, word address width (32-word data memory)
- DATA_W, 32, data word width
- CNT_W, 16, width of contention counter

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- p0_req / p1_req  in  1  access request; held with its fields until granted
- p0_we / p1_we  in  1  1 = write, 0 = read
- p0_addr / p1_addr  in  ADDR_W  word address
- p0_wdata / p1_wdata  in  DATA_W  write data
- p0_gnt / p1_gnt  out  1  combinational; access accepted this cycle
- p0_rvalid / p1_rvalid  out  1  registered; read data valid this cycle
- p0_rdata / p1_rdata  out  DATA_W  read data; zero when that port's rvalid = 0
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe
- conflict_cnt  out  CNT_W  saturating count of cycles with both requests high

## Operation
- Each cycle with any request: exactly one gnt asserted; mem_en = 1; mem_we/addr/wdata muxed from granted port. No request: both gnt = 0, mem_en = 0, mem_we = 0, mem_addr/wdata = 0.
- Single requester: always granted that cycle.
- Both requesting: winner chosen per Configuration; loser holds req and fields stable.
- Write: complete at the rising edge ending the grant cycle; no rvalid.
- Read: owner flag and read-pending registered at grant edge; next cycle that port's rvalid = 1 and rdata = mem_rdata; other port rdata = 0.
- Back-to-back reads, same or alternating ports, sustain one per cycle; owner flag tracks each independently.
- last_gnt register: updated to granted port index on every grant.
- conflict_cnt: +1 each cycle with p0_req & p1_req; holds at 2^CNT_W-1.
- Reset: gnt combinational but forced 0 while rst = 1; rvalid 0, rdata 0, last_gnt = 1 (port 0 preferred next), conflict_cnt 0, read-pending cleared. Read granted in the cycle before reset asserts produces no rvalid.

## Timing
- Grant latency: 0 cycles (same cycle as req when winning).
- Read latency: rvalid exactly 1 cycle after gnt cycle.
- Throughput: 1 access/cycle aggregate.
- gnt depends combinationally on req and last_gnt only; no path from mem_rdata to gnt.
- rvalid/owner/last_gnt/conflict_cnt all registered; rdata is a mux of mem_rdata by registered owner.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin on contention; winner is port != last_gnt; two continuously requesting ports alternate every cycle.
- Not defined: fixed priority, port 0 always wins contention; port 1 may starve while port 0 requests; last_gnt still maintained but unused for selection.

## Test plan
- Reset: hold rst 3 cycles with both req high -> both gnt 0, mem_en 0, conflict_cnt 0, rvalid 0; first cycle after reset both req -> p0_gnt = 1.
- Single read: memory word 5 = 0xDEADBEEF, p1 reads addr 5 -> p1_gnt same cycle, next cycle p1_rvalid = 1, p1_rdata = 0xDEADBEEF, p0_rvalid = 0, p0_rdata = 0.
- Write then read: p0 writes 0x12345678 to addr 3, next cycle p1 reads addr 3 -> p1_rdata = 0x12345678.
- Contention 6 cycles, both read distinct addrs: RR build -> grants alternate p0,p1,p0,p1,p0,p1 and rvalid alternates one cycle later; fixed build -> p0 granted all 6, p1_gnt never; conflict_cnt = 6 in both.
- Reset mid-read: p0 read granted at cycle N, rst high at cycle N+1 -> p0_rvalid stays 0.
- Saturation with CNT_W = 4: 20 contention cycles -> conflict_cnt = 15.
